// File: rtl/spi_pkg.sv
// Shared frame geometry, FSM encoding and frame packing for the SPI command transmitter.
package spi_pkg;

    localparam int FRAME_BYTES = 7;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;

    localparam int CMD_IDX  = 0;
    localparam int ADDR_IDX = 1;
    localparam int DATA_IDX = 3;

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_e;

    // Bit 0 of the result is the first bit on the wire (cmd[0]); multi-byte
    // fields land little-endian so an LSB-first shift yields the byte order.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0]  cmd,
        input logic [15:0] addr,
        input logic [31:0] data
    );
        logic [FRAME_BITS-1:0] frame;
        frame = '0;
        frame[CMD_IDX*8  +: 8]  = cmd;
        frame[ADDR_IDX*8 +: 16] = addr;
        frame[DATA_IDX*8 +: 32] = data;
        return frame;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// sck phase generator: one tick every CLK_DIV enabled cycles, alternating
// between rise and fall; held at zero whenever disabled or cleared.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic       phase_q;
    logic       tick;

    assign tick      = enable && (cnt_q == RELOAD);
    assign rise_tick = tick && !phase_q;
    assign fall_tick = tick && phase_q;

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == RELOAD) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master that shifts one 56-bit command frame (cmd, addr, data)
// LSB first, framed by cs with a lead-in, trailer and minimum inter-frame gap.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [15:0] addr,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        cs,
    output logic        sck,
    output logic        mosi
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    spi_state_e            state_q;
    spi_state_e            state_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [5:0]            bit_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  cs_q;
    logic                  sck_q;
    logic                  done_q;
    logic                  div_en;
    logic                  div_clear;
    logic                  rise_tick;
    logic                  fall_tick;

    // Handshake: start is taken only while busy=0 (IDLE); busy then stays high
    // through the frame and the gap, and any start seen while busy is dropped.
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign cs   = cs_q;
    assign sck  = sck_q;
    assign mosi = shift_q[0];

    // The divider also times LEAD and TRAIL: its first tick after a clear is
    // a "rise" tick, which marks the end of either window.
    assign div_en    = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);
    assign div_clear = (state_q == SHIFT) && (state_d != SHIFT);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .enable   (div_en),
        .clear    (div_clear),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LEAD;
            LEAD:    if (rise_tick) state_d = SHIFT;
            SHIFT:   if (fall_tick && (bit_cnt_q == LAST_BIT)) state_d = TRAIL;
            TRAIL:   if (rise_tick) state_d = GAP;
            GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= build_frame(cmd, addr, data);
                        bit_cnt_q <= '0;
                        gap_cnt_q <= '0;
                        cs_q      <= 1'b0;
                    end
                end
                LEAD: begin
                    if (rise_tick) sck_q <= 1'b1;
                end
                SHIFT: begin
                    if (rise_tick) sck_q <= 1'b1;
                    if (fall_tick) begin
                        sck_q <= 1'b0;
                        // The last bit is held on mosi through TRAIL.
                        if (bit_cnt_q != LAST_BIT) begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            shift_q   <= {1'b0, shift_q[FRAME_BITS-1:1]};
                        end
                    end
                end
                TRAIL: begin
                    if (rise_tick) begin
                        cs_q    <= 1'b1;
                        shift_q <= '0;
                        done_q  <= 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? '0 : gap_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and CLK_DIV=1) checked every
// cycle against a timing-formula model, plus a receiver that reassembles frames.
module tb_spi_master_tx;

    localparam int D0 = 4;
    localparam int G0 = 4;
    localparam int D1 = 1;
    localparam int G1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       start_v = '0;
    logic [1:0][7:0]  cmd_v   = '0;
    logic [1:0][15:0] addr_v  = '0;
    logic [1:0][31:0] data_v  = '0;
    logic [1:0]       busy_v, done_v, cs_v, sck_v, mosi_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spi_master_tx #(.CLK_DIV(D0), .GAP_CYC(G0)) u_dut_div4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
        .data(data_v[0]), .busy(busy_v[0]), .done(done_v[0]), .cs(cs_v[0]),
        .sck(sck_v[0]), .mosi(mosi_v[0])
    );

    spi_master_tx #(.CLK_DIV(D1), .GAP_CYC(G1)) u_dut_div1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
        .data(data_v[1]), .busy(busy_v[1]), .done(done_v[1]), .cs(cs_v[1]),
        .sck(sck_v[1]), .mosi(mosi_v[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          active[2];
    int          t_acc[2];
    logic [55:0] frame_m[2];

    function automatic int dv(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int gp(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Wire order: cmd, addr lo, addr hi, data bytes 0..3; each byte LSB first.
    function automatic logic [55:0] frame_of(input logic [7:0] c, input logic [15:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b[7];
        logic [55:0] f;
        b[0] = c;        b[1] = a[7:0];    b[2] = a[15:8];
        b[3] = d[7:0];   b[4] = d[15:8];   b[5] = d[23:16]; b[6] = d[31:24];
        for (int n = 0; n < 56; n++) f[n] = b[n / 8][n % 8];
        return f;
    endfunction

    // Returns {cs, sck, mosi, busy, done} expected in cycle c.
    function automatic logic [4:0] exp_out(input int i, input int c);
        int   r, d, len, bi;
        logic cs_e, sck_e, mosi_e, busy_e, done_e;
        r = active[i] ? (c - t_acc[i] - 1) : -1;
        d = dv(i);
        len = 113 * d;
        cs_e = 1'b1; sck_e = 1'b0; mosi_e = 1'b0;
        if (r >= 0 && r < len) begin
            cs_e  = 1'b0;
            sck_e = ((r / d) % 2) == 1;
            bi    = (r / d) / 2;
            if (bi > 55) bi = 55;
            mosi_e = frame_m[i][bi];
        end
        busy_e = (r >= 0) && (r < len + gp(i));
        done_e = (r == len);
        return {cs_e, sck_e, mosi_e, busy_e, done_e};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                active[i] = 1'b0;
            end else if (start_v[i] && !exp_out(i, cyc)[1]) begin
                active[i]  = 1'b1;
                t_acc[i]   = cyc;
                frame_m[i] = frame_of(cmd_v[i], addr_v[i], data_v[i]);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] e;
                e = exp_out(i, cyc);
                check($sformatf("cs[%0d]@%0d", i, cyc),   cs_v[i],   e[4]);
                check($sformatf("sck[%0d]@%0d", i, cyc),  sck_v[i],  e[3]);
                check($sformatf("mosi[%0d]@%0d", i, cyc), mosi_v[i], e[2]);
                check($sformatf("busy[%0d]@%0d", i, cyc), busy_v[i], e[1]);
                check($sformatf("done[%0d]@%0d", i, cyc), done_v[i], e[0]);
            end
        end
    end

    // ---------------- receiver + scoreboard ----------------
    logic [55:0] exp_q0[$];
    logic [55:0] exp_q1[$];
    logic [55:0] rx_bits[2];
    logic [55:0] rx_last[2];
    int          rx_n[2];
    int          rx_last_n[2];
    int          total_rises[2];
    int          done_cnt[2];
    logic [1:0]  sck_prev = 2'b00;
    logic [1:0]  cs_prev  = 2'b11;

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                logic [55:0] want;
                int          qs;
                if (sck_v[i] && !sck_prev[i]) begin
                    total_rises[i]++;
                    if (rx_n[i] < 56) rx_bits[i][rx_n[i]] = mosi_v[i];
                    rx_n[i]++;
                end
                if (done_v[i]) done_cnt[i]++;
                if (cs_v[i] && !cs_prev[i] && rx_n[i] > 0) begin
                    rx_last[i]   = rx_bits[i];
                    rx_last_n[i] = rx_n[i];
                    qs = (i == 0) ? exp_q0.size() : exp_q1.size();
                    check($sformatf("sb_expected_frame[%0d]", i), qs > 0, 1'b1);
                    if (qs > 0) begin
                        want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("sb_frame[%0d]", i), rx_bits[i], want);
                        check($sformatf("sb_rises[%0d]", i), rx_n[i], 56);
                    end
                    rx_n[i] = 0;
                end
                if (rst) rx_n[i] = 0;
                sck_prev[i] = sck_v[i];
                cs_prev[i]  = cs_v[i];
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int i, input logic [7:0] c, input logic [15:0] a,
                        input logic [31:0] d, output int t);
        int guard = 0;
        while (busy_v[i] !== 1'b0 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("idle_wait[%0d]", i), guard < 2000, 1'b1);
        cmd_v[i] = c; addr_v[i] = a; data_v[i] = d;
        start_v[i] = 1'b1;
        t = cyc;
        if (i == 0) exp_q0.push_back(frame_of(c, a, d));
        else        exp_q1.push_back(frame_of(c, a, d));
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        cmd_v[i] = 8'($urandom); addr_v[i] = 16'($urandom); data_v[i] = $urandom;
    endtask

    task automatic pulse_start(input int i);
        cmd_v[i] = 8'hFF;
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
    endtask

    task automatic wait_frame(input int i, output int dc);
        int guard = 0;
        while (done_v[i] !== 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("done_seen[%0d]", i), guard < 2000, 1'b1);
        dc = cyc;
        @(negedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int t, t2, dc, d0, r0, n, spur;
        logic [7:0]  rc;
        logic [15:0] ra;
        logic [31:0] rd;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_cs", cs_v[0], 1'b1);
        check("reset_sck", sck_v[0], 1'b0);
        check("reset_busy", busy_v[1], 1'b0);

        // Basic frame on the CLK_DIV=4 instance.
        send(0, 8'hA5, 16'h1234, 32'hDEADBEEF, t);
        wait_frame(0, dc);
        check("basic_stream", rx_last[0], 56'hDEADBEEF_1234_A5);
        check("basic_rises", rx_last_n[0], 56);
        check("basic_done_cycle", dc, t + 1 + 452);

        // Loopback: fields recovered from the wire.
        send(0, 8'h3C, 16'h00FF, 32'h01020304, t);
        wait_frame(0, dc);
        check("loop_cmd",  rx_last[0][7:0],   8'h3C);
        check("loop_addr", rx_last[0][23:8],  16'h00FF);
        check("loop_data", rx_last[0][55:24], 32'h01020304);

        // Busy rejection mid-frame and during the gap.
        d0 = done_cnt[0];
        send(0, 8'h11, 16'h2233, 32'h44556677, t);
        repeat (100) @(posedge clk);
        #1;
        pulse_start(0);
        wait_frame(0, dc);
        pulse_start(0);
        send(0, 8'h5A, 16'hC3C3, 32'h0F0F0F0F, t2);
        check("gap_first_idle_start", t2, dc + G0);
        check("gap_cs_high_len", (t2 + 1 - dc) >= G0, 1'b1);
        wait_frame(0, dc);
        check("reject_done_count", done_cnt[0] - d0, 2);
        check("reject_last_frame", rx_last[0], 56'h0F0F0F0F_C3C3_5A);

        // CLK_DIV=1 instance.
        send(1, 8'h80, 16'h0000, 32'hFFFFFFFF, t);
        wait_frame(1, dc);
        check("div1_stream", rx_last[1], 56'hFFFFFFFF_0000_80);
        check("div1_rises", rx_last_n[1], 56);
        check("div1_done_cycle", dc, t + 114);

        // Reset at bit 20; a start coinciding with reset on the other instance.
        d0 = done_cnt[0];
        send(0, 8'hC7, 16'hBEEF, 32'h12345678, t);
        n = 0;
        while (rx_n[0] < 20 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_bit20", n < 2000, 1'b1);
        rst = 1'b1;
        start_v[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_v[1] = 1'b0;
        exp_q0.delete();
        check("midrst_cs", cs_v[0], 1'b1);
        check("midrst_sck", sck_v[0], 1'b0);
        check("midrst_mosi", mosi_v[0], 1'b0);
        check("midrst_busy", busy_v[0], 1'b0);
        check("rst_start_ignored", busy_v[1], 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt[0], d0);
        send(0, 8'h96, 16'h7E81, 32'hCAFEF00D, t);
        wait_frame(0, dc);
        check("after_rst_frame", rx_last[0], 56'hCAFEF00D_7E81_96);

        // Back-to-back streaming, random payloads.
        d0 = done_cnt[0];
        r0 = total_rises[0];
        for (int k = 0; k < 3; k++) begin
            send(0, 8'($urandom), 16'($urandom), $urandom, t);
        end
        wait_frame(0, dc);
        check("stream_dones", done_cnt[0] - d0, 3);
        check("stream_rises", total_rises[0] - r0, 168);

        // Randomized frames on either instance with spurious busy-time starts.
        for (int k = 0; k < 8; k++) begin
            int i;
            i  = $urandom_range(0, 1);
            rc = 8'($urandom); ra = 16'($urandom); rd = $urandom;
            send(i, rc, ra, rd, t);
            spur = $urandom_range(1, 100);
            repeat (spur) @(posedge clk);
            #1;
            pulse_start(i);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end

        n = 0;
        while ((busy_v !== 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
SPI master that serialises one 7-byte command frame (cmd, 16-bit addr, 32-bit data) onto cs/sck/mosi for the team's SPI slave receiver.
- Runs on the system clock and generates sck internally by division.
- Presents a start/busy/done handshake to the local controller.
- Transmit only: no miso path.

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles (legal range 1..255; sck frequency = clk/(2*CLK_DIV)).
- GAP_CYC, 4, minimum cs-high cycles between frames (legal range >=1).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- cmd  in  8  command byte, captured on accepted start.
- addr  in  16  address, captured on accepted start.
- data  in  32  payload, captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until the inter-frame gap ends.
- done  out  1  one-cycle pulse in the cycle cs returns high.
- cs  out  1  chip select, active low, registered.
- sck  out  1  serial clock, idle low (mode 0), registered.
- mosi  out  1  serial data, registered.

Behaviour:
- Reset values: cs=1, sck=0, mosi=0, busy=0, done=0. The FSM is in IDLE and all counters are 0.
- Frame byte order: byte0=cmd, byte1=addr[7:0], byte2=addr[15:8], byte3=data[7:0], byte4=data[15:8], byte5=data[23:16], byte6=data[31:24].
- Bit order: LSB first within each byte, giving 56 bits total.
- Handshake:
  - start with busy=0 in cycle T latches a 56-bit shift register.
  - start while busy=1 is ignored, with no queueing.
  - Inputs may change after T.
- FSM states and transitions:
  - IDLE -> LEAD on accepted start.
  - At T+1: cs=0, mosi=bit0, busy=1.
  - LEAD lasts CLK_DIV cycles; then sck rises (first rise at T+1+CLK_DIV).
  - SHIFT: sck toggles every CLK_DIV cycles.
    - Rise k (k=0..55) occurs at T+1+(2k+1)*CLK_DIV.
    - Fall k occurs at T+1+(2k+2)*CLK_DIV.
    - On each fall except the last, mosi advances to the next bit in the same cycle. mosi is therefore stable for CLK_DIV cycles on both sides of every rise.
  - After fall 55, go to TRAIL. mosi holds bit55.
  - TRAIL lasts CLK_DIV cycles. Then cs=1, mosi=0 and done=1 for that one cycle, at T+1+113*CLK_DIV. Go to GAP.
  - GAP lasts GAP_CYC cycles with busy=1; then IDLE with busy=0.
  - Earliest next accepted start is the cycle busy is first 0.
- Counters:
  - Bit counter is 6 bits, 0..55, with no wrap inside a frame.
  - Divider counter is 8 bits, reloading at CLK_DIV-1.
- Exactly 56 sck rising edges per frame. sck is never high while cs=1.
- Reset mid-frame:
  - In the next cycle, outputs return to reset values and the frame is abandoned with no done pulse.
  - A partial frame leaves the receiver's bit/byte counters misaligned. The system must resynchronise the receiver by its own means; this block takes no action.
- start asserted in the same cycle as rst is ignored.
- CLK_DIV=1 is legal: sck = clk/2 and all timing formulas above hold.

Decomposition:
- Package spi_pkg holds:
  - FRAME_BYTES=7, FRAME_BITS=56.
  - Byte index constants: CMD_IDX=0, ADDR_IDX=1, DATA_IDX=3.
  - FSM state enum {IDLE, LEAD, SHIFT, TRAIL, GAP}.
- One sub-module, spi_clk_div: parameterised by CLK_DIV, with enable input and single-cycle tick outputs rise_tick/fall_tick. It is cleared whenever the FSM leaves SHIFT.
- Shift register and FSM stay in spi_master_tx.

Test Plan:
- Basic frame, CLK_DIV=4: start with cmd=0xA5, addr=0x1234, data=0xDEADBEEF. The bench samples mosi on each sck rise.
  -> Byte stream is A5 34 12 EF BE AD DE, LSB first.
  -> Exactly 56 rises; done at T+1+452.
- Loopback: connect outputs to the SPI slave receiver.
  -> After cs rises, the receiver presents cmd=0x3C, addr=0x00FF, data=0x01020304, matching the stimulus.
- Busy rejection: second start with cmd=0xFF issued mid-frame and during GAP.
  -> Ignored; only one frame emitted.
  -> Start in the first busy=0 cycle is accepted, and cs stays high for >= GAP_CYC cycles between frames.
- CLK_DIV=1: data=0xFFFFFFFF, addr=0, cmd=0x80.
  -> sck toggles every cycle; mosi stable at each rise.
  -> done at T+114.
- Reset mid-frame: assert rst at bit 20.
  -> Next cycle cs=1, sck=0, mosi=0, busy=0; no done pulse.
  -> A following start produces a full, correct 56-bit frame.
- Back-to-back streaming: 3 frames, each started on the first busy=0 cycle.
  -> 3 done pulses; sck low whenever cs=1; 168 total sck rises.
